// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm
//   Multi-cycle MIPS-subset control unit. Sequences each instruction through
//   FETCH -> DECODE -> EXEC -> MEM -> WB (skipping phases the instruction does
//   not need), drives the datapath strobes and selects, and counts retired
//   instructions.
//
// Parameters
//   MEM_HANDSHAKE  1: FETCH/MEM wait for mem_ready; 0: mem_ready treated as 1
//   SYSCALL_HALT   1: syscall enters HALT; 0: syscall retires as a no-op
//   CNT_W          width of instr_cnt
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   opcode, fn               IR[31:26] / IR[5:0], sampled in DECODE
//   zero, neg                ALU flags, sampled in EXEC
//   mem_ready                memory transfer completes this cycle
//   pc_we, ir_we, reg_we     register write strobes
//   mem_re, mem_we           memory read / write strobes
//   pc_src                   00 PC+4, 01 branch, 10 jump, 11 rs
//   alu_op                   0 ADD 1 SUB 2 SLT 3 AND 4 OR 5 XOR 6 NOR 7 LUI
//   alu_src_b                00 rt, 01 sign-ext imm, 10 zero-ext imm
//   reg_dst                  00 rt, 01 rd, 10 $31
//   mem_to_reg               00 ALU, 01 memory data, 10 PC+4
//   state                    current FSM state (FETCH 0 .. HALT 5)
//   halted, illegal          in HALT / unsupported instruction in DECODE
//   instr_cnt                retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module mc_ctrl_fsm #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int SYSCALL_HALT  = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       fn,
  input  logic             zero,
  input  logic             neg,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ir_we,
  output logic             reg_we,
  output logic             mem_re,
  output logic             mem_we,
  output logic [1:0]       pc_src,
  output logic [3:0]       alu_op,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [4:0] {
    C_NONE, C_ADD, C_SUB, C_SLT, C_AND, C_OR, C_XOR, C_NOR,
    C_ADDI, C_SLTI, C_ANDI, C_ORI, C_XORI, C_LUI,
    C_LW, C_SW, C_J, C_JAL, C_JR, C_BEQ, C_BNE, C_BLTZ,
    C_SYSCALL, C_ILLEGAL
  } class_t;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SLT = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_NOR = 4'd6;
  localparam logic [3:0] ALU_LUI = 4'd7;

  state_t           state_q, state_d;
  class_t           class_q, class_d;
  class_t           dec_class;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic             mem_rdy;
  logic             is_rtype;

  // With the handshake disabled every memory transfer is single-cycle.
  assign mem_rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  assign is_rtype = (class_q inside {C_ADD, C_SUB, C_SLT, C_AND, C_OR, C_XOR, C_NOR});

  // Map the raw opcode/fn pair onto an instruction class; anything outside
  // the supported subset becomes C_ILLEGAL. Opcode 1 (REGIMM) is bltz.
  always_comb begin
    dec_class = C_ILLEGAL;
    case (opcode)
      6'h00: begin
        case (fn)
          6'h20:   dec_class = C_ADD;
          6'h22:   dec_class = C_SUB;
          6'h2A:   dec_class = C_SLT;
          6'h24:   dec_class = C_AND;
          6'h25:   dec_class = C_OR;
          6'h26:   dec_class = C_XOR;
          6'h27:   dec_class = C_NOR;
          6'h08:   dec_class = C_JR;
          6'h0C:   dec_class = C_SYSCALL;
          default: dec_class = C_ILLEGAL;
        endcase
      end
      6'h01:   dec_class = C_BLTZ;
      6'h02:   dec_class = C_J;
      6'h03:   dec_class = C_JAL;
      6'h04:   dec_class = C_BEQ;
      6'h05:   dec_class = C_BNE;
      6'h08:   dec_class = C_ADDI;
      6'h0A:   dec_class = C_SLTI;
      6'h0C:   dec_class = C_ANDI;
      6'h0D:   dec_class = C_ORI;
      6'h0E:   dec_class = C_XORI;
      6'h0F:   dec_class = C_LUI;
      6'h23:   dec_class = C_LW;
      6'h2B:   dec_class = C_SW;
      default: dec_class = C_ILLEGAL;
    endcase
  end

  // Next-state and output logic. Every output defaults to 0; while reset is
  // held the case is skipped entirely so no strobe can leak out.
  always_comb begin
    state_d    = state_q;
    class_d    = class_q;
    retire     = 1'b0;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    pc_src     = 2'b00;
    alu_op     = ALU_ADD;
    alu_src_b  = 2'b00;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    halted     = 1'b0;
    illegal    = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_re = 1'b1;
          if (mem_rdy) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          class_d = dec_class;
          case (dec_class)
            C_J: begin
              pc_we   = 1'b1;
              pc_src  = 2'b10;
              retire  = 1'b1;
              state_d = S_FETCH;
            end
            C_JAL: begin
              pc_we      = 1'b1;
              pc_src     = 2'b10;
              reg_we     = 1'b1;
              reg_dst    = 2'b10;
              mem_to_reg = 2'b10;
              retire     = 1'b1;
              state_d    = S_FETCH;
            end
            C_JR: begin
              pc_we   = 1'b1;
              pc_src  = 2'b11;
              retire  = 1'b1;
              state_d = S_FETCH;
            end
            C_SYSCALL: begin
              retire  = 1'b1;
              state_d = (SYSCALL_HALT != 0) ? S_HALT : S_FETCH;
            end
            C_ILLEGAL: begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
            default: state_d = S_EXEC;
          endcase
        end
        S_EXEC: begin
          case (class_q)
            C_ADD, C_ADDI, C_LW, C_SW:     alu_op = ALU_ADD;
            C_SUB, C_BEQ, C_BNE, C_BLTZ:   alu_op = ALU_SUB;
            C_SLT, C_SLTI:                 alu_op = ALU_SLT;
            C_AND, C_ANDI:                 alu_op = ALU_AND;
            C_OR, C_ORI:                   alu_op = ALU_OR;
            C_XOR, C_XORI:                 alu_op = ALU_XOR;
            C_NOR:                         alu_op = ALU_NOR;
            C_LUI:                         alu_op = ALU_LUI;
            default:                       alu_op = ALU_ADD;
          endcase
          case (class_q)
            C_ADDI, C_SLTI, C_LW, C_SW, C_LUI: alu_src_b = 2'b01;
            C_ANDI, C_ORI, C_XORI:             alu_src_b = 2'b10;
            default:                           alu_src_b = 2'b00;
          endcase
          case (class_q)
            C_LW, C_SW: state_d = S_MEM;
            C_BEQ, C_BNE, C_BLTZ: begin
              pc_src  = 2'b01;
              pc_we   = (class_q == C_BEQ) ? zero :
                        (class_q == C_BNE) ? ~zero : neg;
              retire  = 1'b1;
              state_d = S_FETCH;
            end
            C_ADD, C_SUB, C_SLT, C_AND, C_OR, C_XOR, C_NOR,
            C_ADDI, C_SLTI, C_ANDI, C_ORI, C_XORI, C_LUI: state_d = S_WB;
            default: state_d = S_FETCH;
          endcase
        end
        S_MEM: begin
          alu_op    = ALU_ADD;
          alu_src_b = 2'b01;
          mem_re    = (class_q == C_LW);
          mem_we    = (class_q == C_SW);
          if (mem_rdy) begin
            if (class_q == C_LW) begin
              state_d = S_WB;
            end else begin
              retire  = 1'b1;
              state_d = S_FETCH;
            end
          end
        end
        S_WB: begin
          reg_we     = 1'b1;
          reg_dst    = is_rtype ? 2'b01 : 2'b00;
          mem_to_reg = (class_q == C_LW) ? 2'b01 : 2'b00;
          retire     = 1'b1;
          state_d    = S_FETCH;
        end
        S_HALT: halted = 1'b1;
        default: state_d = S_FETCH;
      endcase
    end
  end

  // The counter wraps naturally at 2^CNT_W.
  assign cnt_d = cnt_q + CNT_W'(retire);

  // State, class and retire-count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      class_q <= C_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule
